mult_stim_checker: RTL and testbench
====================================

Name: mult_stim_checker

Overview:
- Self-checking stimulus/response stage wrapped around a candidate `multiplier` netlist (ports A, B, P) emitted by the design-space exploration flow.
- Sits directly upstream (drives A/B) and downstream (samples P) of the multiplier under evaluation.
- Sweeps operand pairs, compares P against the exact product, and accumulates error statistics.
- The RL reward script reads these statistics instead of parsing per-vector `$display` output.

Parameters:
- WIDTH, 2, operand width in bits; P is 2*WIDTH bits.
- NUM_VECTORS, 16, number of operand pairs applied per run (1 .. 65535).
- SETTLE_CYCLES, 1, cycles A/B are held stable before P is sampled (>= 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run (honoured only in IDLE or DONE).
- A  out  WIDTH  operand A to the multiplier, registered.
- B  out  WIDTH  operand B to the multiplier, registered.
- P  in  2*WIDTH  product from the multiplier (combinational path from A/B).
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next start or reset.
- vec_count  out  16  vectors checked in the current/last run.
- err_count  out  16  vectors where P != A*B; saturates at 16'hFFFF.
- sum_abs_err  out  32  sum of |P - A*B|; saturates at 32'hFFFFFFFF.
- max_abs_err  out  2*WIDTH  largest |P - A*B| seen in the run.

Behaviour:
- Reset (async, any state): all of the following are 0, and state = IDLE:
  - A, B, busy, done, vec_count, err_count, sum_abs_err, max_abs_err, internal index.
  - Reset mid-run aborts the run; no partial results are retained.
- Vector order: index i runs from 0 to NUM_VECTORS-1.
  - A = i[2W-1:W], B = i[W-1:0] (exhaustive sweep).
  - The index wraps modulo 2^(2W), so NUM_VECTORS > 2^(2W) repeats pairs from {0,0}.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE/DONE + start:
    - load A/B from i=0;
    - clear all statistics and vec_count;
    - busy=1, done=0; go to SETTLE with settle counter = SETTLE_CYCLES.
  - SETTLE: decrement the settle counter each cycle; after exactly SETTLE_CYCLES cycles in SETTLE, go to CHECK. A/B are constant throughout.
  - CHECK (one cycle): sample P and compute exact = A*B at 2W-bit width (no truncation possible).
    - diff = |P - exact|, computed unsigned with a compare-and-swap subtract.
    - If diff != 0, increment err_count (saturating).
    - sum_abs_err += diff (saturating).
    - max_abs_err = max(max_abs_err, diff).
    - vec_count increments.
    - If vec_count (after increment) == NUM_VECTORS: go to DONE with busy=0, done=1; A/B hold their last value.
    - Otherwise: load A/B for the next index and go to SETTLE.
  - DONE: statistics are frozen and done stays high.
- Latency: each vector costs SETTLE_CYCLES+1 cycles. done rises (NUM_VECTORS)*(SETTLE_CYCLES+1) cycles after the start edge.
- start while busy is ignored and has no effect on the run.
- Statistics update only in CHECK, and are stable and readable at all other times.

Test Plan:
- Exact multiplier, WIDTH=2, NUM_VECTORS=16, SETTLE_CYCLES=1, pulse start:
  - done rises 32 cycles after start;
  - vec_count=16, err_count=0, sum_abs_err=0, max_abs_err=0.
- Faulty model with P bit0 stuck at 0:
  - errors at (1,1), (1,3), (3,1), (3,3);
  - err_count=4, sum_abs_err=4, max_abs_err=1.
- Model with P tied to 0:
  - err_count=9, sum_abs_err=36, max_abs_err=9;
  - A/B in DONE are 3/3.
- NUM_VECTORS=20, exact model:
  - vectors 16..19 re-apply {0,0},{0,1},{0,2},{0,3};
  - vec_count=20, err_count=0.
- Start pulse repeated at cycle 5 of a run:
  - ignored; completion timing and results are identical to a single start.
  - A second start while in DONE clears the stats and reruns.
- Assert rst at cycle 10 of a run with the P=0 model:
  - all outputs are 0 immediately;
  - a subsequent start produces the full err_count=9 result.

Source files
------------

// File: rtl/mult_stim_checker_if.sv
// Operand/product and status bundle between the stimulus checker and the
// multiplier under evaluation plus whoever reads the statistics.
interface mult_stim_checker_if #(
  parameter int WIDTH = 2
);
  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   P;
  logic                 busy;
  logic                 done;
  logic [15:0]          vec_count;
  logic [15:0]          err_count;
  logic [31:0]          sum_abs_err;
  logic [2*WIDTH-1:0]   max_abs_err;

  // Checker side: drives operands and statistics, samples the product.
  modport master (
    input  start, P,
    output A, B, busy, done, vec_count, err_count, sum_abs_err, max_abs_err
  );

  // Environment side: multiplier plus run controller.
  modport slave (
    output start, P,
    input  A, B, busy, done, vec_count, err_count, sum_abs_err, max_abs_err
  );
endinterface

// File: rtl/mult_stim_checker.sv
// Exhaustive-sweep stimulus generator and response checker for a candidate
// combinational multiplier. Accumulates error statistics for one run.
module mult_stim_checker #(
  parameter int WIDTH         = 2,
  parameter int NUM_VECTORS   = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mult_stim_checker_if.master   bus
);
  localparam int PW  = 2 * WIDTH;
  localparam int SCW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [SCW-1:0]    cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [15:0]       vec_q, vec_d, err_q, err_d;
  logic [31:0]       sum_q, sum_d;
  logic [PW-1:0]     max_q, max_d;

  logic [PW-1:0]     exact, diff, idx_nxt;
  logic [32:0]       sum_ext;
  logic [31:0]       sum_sat;
  logic [15:0]       vec_inc, err_sat;

  // Error datapath: exact product fits in PW bits, so no truncation.
  always_comb begin
    exact   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    diff    = (bus.P >= exact) ? (bus.P - exact) : (exact - bus.P);
    sum_ext = {1'b0, sum_q} + 33'(diff);
    sum_sat = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
    err_sat = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
    vec_inc = vec_q + 16'd1;
    idx_nxt = idx_q + PW'(1);
  end

  // Next-state and register updates; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    vec_d   = vec_q;
    err_d   = err_q;
    sum_d   = sum_q;
    max_d   = max_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          idx_d   = '0;
          a_d     = '0;
          b_d     = '0;
          vec_d   = '0;
          err_d   = '0;
          sum_d   = '0;
          max_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = SCW'(SETTLE_CYCLES);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - SCW'(1);
        if (cnt_q == SCW'(1)) state_d = CHECK;
      end
      CHECK: begin
        vec_d = vec_inc;
        if (diff != '0) err_d = err_sat;
        sum_d = sum_sat;
        if (diff > max_q) max_d = diff;
        if (vec_inc == 16'(NUM_VECTORS)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          // Index wraps naturally at 2^PW, repeating the sweep from {0,0}.
          idx_d   = idx_nxt;
          a_d     = idx_nxt[PW-1:WIDTH];
          b_d     = idx_nxt[WIDTH-1:0];
          cnt_d   = SCW'(SETTLE_CYCLES);
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any run and discards partial results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vec_q   <= '0;
      err_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
    end
  end

  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.vec_count   = vec_q;
  assign bus.err_count   = err_q;
  assign bus.sum_abs_err = sum_q;
  assign bus.max_abs_err = max_q;
endmodule

// File: tb/tb_mult_stim_checker.sv
// Directed bench: two checker instances (16- and 20-vector runs) around a
// behavioural multiplier with selectable fault modes, scoreboarded per run.
module tb_mult_stim_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;
  logic [1:0] st = 2'b00;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  mult_stim_checker_if #(.WIDTH(2)) if0 ();
  mult_stim_checker_if #(.WIDTH(2)) if1 ();

  mult_stim_checker #(.WIDTH(2), .NUM_VECTORS(16), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  mult_stim_checker #(.WIDTH(2), .NUM_VECTORS(20), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));

  // Mode 0 exact, 1 bit0 stuck at 0, 2 output tied to 0.
  function automatic logic [3:0] mul_model(input logic [1:0] a, input logic [1:0] b, input int m);
    logic [3:0] ex;
    ex = {2'b00, a} * {2'b00, b};
    case (m)
      1:       return ex & 4'b1110;
      2:       return 4'd0;
      default: return ex;
    endcase
  endfunction

  always_comb if0.P = mul_model(if0.A, if0.B, mode);
  always_comb if1.P = mul_model(if1.A, if1.B, mode);
  assign if0.start = st[0];
  assign if1.start = st[1];

  logic        dn[2], bz[2];
  logic [15:0] vc[2], ec[2];
  logic [31:0] sa[2];
  logic [3:0]  ma[2];
  logic [1:0]  aa[2], bb[2];
  assign dn[0] = if0.done;        assign dn[1] = if1.done;
  assign bz[0] = if0.busy;        assign bz[1] = if1.busy;
  assign vc[0] = if0.vec_count;   assign vc[1] = if1.vec_count;
  assign ec[0] = if0.err_count;   assign ec[1] = if1.err_count;
  assign sa[0] = if0.sum_abs_err; assign sa[1] = if1.sum_abs_err;
  assign ma[0] = if0.max_abs_err; assign ma[1] = if1.max_abs_err;
  assign aa[0] = if0.A;           assign aa[1] = if1.A;
  assign bb[0] = if0.B;           assign bb[1] = if1.B;

  typedef struct {
    int unsigned vec, err, sum, mx, a, b, lat;
  } exp_t;
  exp_t sb[$];
  int   seq_q[$];

  function automatic exp_t model(input int n, input int m);
    exp_t e;
    int idx, a, b, ex, p, d;
    e = '{default: 0};
    for (int i = 0; i < n; i++) begin
      idx = i % 16; a = idx / 4; b = idx % 4;
      ex = a * b;
      p = int'(mul_model(2'(a), 2'(b), m));
      d = (p > ex) ? p - ex : ex - p;
      if (d != 0) e.err++;
      e.sum += d;
      if (d > e.mx) e.mx = d;
      e.a = a; e.b = b;
    end
    e.vec = n;
    e.lat = n * 2;
    return e;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int s, input string tag);
    chk({tag, "_A"}, aa[s], 0);       chk({tag, "_B"}, bb[s], 0);
    chk({tag, "_busy"}, bz[s], 0);    chk({tag, "_done"}, dn[s], 0);
    chk({tag, "_vec"}, vc[s], 0);     chk({tag, "_err"}, ec[s], 0);
    chk({tag, "_sum"}, sa[s], 0);     chk({tag, "_max"}, ma[s], 0);
  endtask

  task automatic run(input int s, input int m, input int n, input int restart_at, input int abort_at);
    exp_t e;
    int   cyc, idx;
    mode = m;
    sb.push_back(model(n, m));
    seq_q.delete();
    if (s == 1) for (int i = 0; i < n; i++) seq_q.push_back(i % 16);
    @(negedge clk); st[s] = 1'b1;
    @(negedge clk); st[s] = 1'b0; cyc = 0;
    chk("busy_after_start", bz[s], 1);
    while (!dn[s] && cyc < 200) begin
      if (s == 1 && cyc % 2 == 1 && seq_q.size() > 0) begin
        idx = seq_q.pop_front();
        chk("seq_A", aa[1], idx / 4);
        chk("seq_B", bb[1], idx % 4);
      end
      st[s] = (cyc == restart_at);
      if (cyc == abort_at) begin
        rst = 1'b1;
        #1;
        chk_zero(s, "abort");
        void'(sb.pop_front());
        @(negedge clk); rst = 1'b0;
        return;
      end
      @(negedge clk); cyc++;
    end
    st[s] = 1'b0;
    e = sb.pop_front();
    chk("done_seen", dn[s], 1);
    chk("latency", cyc, e.lat);
    chk("vec_count", vc[s], e.vec);
    chk("err_count", ec[s], e.err);
    chk("sum_abs_err", sa[s], e.sum);
    chk("max_abs_err", ma[s], e.mx);
    chk("done_A", aa[s], e.a);
    chk("done_B", bb[s], e.b);
    chk("done_busy", bz[s], 0);
    repeat (3) @(negedge clk);
    chk("frozen_done", dn[s], 1);
    chk("frozen_err", ec[s], e.err);
    chk("frozen_sum", sa[s], e.sum);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    rst = 1'b0;
    @(negedge clk);
    run(0, 0, 16, -1, -1);   // exact model
    run(0, 1, 16, -1, -1);   // bit0 stuck, started from DONE
    run(0, 2, 16, -1, -1);   // P tied to 0
    run(0, 2, 16, 5, -1);    // extra start mid-run ignored
    run(0, 0, 16, -1, -1);   // restart from DONE clears stats
    run(1, 0, 20, -1, -1);   // index wrap with 20 vectors
    run(0, 2, 16, -1, 10);   // reset mid-run
    run(0, 2, 16, -1, -1);   // full result after abort
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
